// File: rtl/cw305_cmd_regs_pkg.sv
// cw305_cmd_pkg: shared constants and types for the CW305 command register block.
//   - Register addresses (REG_INSTR, REG_ADDR, REG_STATUS, REG_RDATA, REG_LEVEL)
//   - STATUS bit positions (ST_*)
//   - status_t: packed view of the STATUS byte, bit 0 is the LSB field
package cw305_cmd_pkg;

   localparam logic [7:0] REG_INSTR  = 8'h00;
   localparam logic [7:0] REG_ADDR   = 8'h01;
   localparam logic [7:0] REG_STATUS = 8'h02;
   localparam logic [7:0] REG_RDATA  = 8'h03;
   localparam logic [7:0] REG_LEVEL  = 8'h04;

   localparam int ST_INSTR_VALID = 0;
   localparam int ST_ADDR_VALID  = 1;
   localparam int ST_BUSY        = 2;
   localparam int ST_RDATA_VALID = 3;
   localparam int ST_FIFO_FULL   = 4;
   localparam int ST_OVERFLOW    = 5;

   // Field order is MSB first so each field lands on its ST_* bit.
   typedef struct packed {
      logic [1:0] reserved;
      logic       overflow;
      logic       fifo_full;
      logic       rdata_valid;
      logic       busy;
      logic       addr_valid;
      logic       instr_valid;
   } status_t;

endpackage

// File: rtl/cw305_cmd_regs_cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO. rdata always shows the head entry.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data (dropped when full unless popping)
//   pop             remove head entry (ignored when empty)
//   rdata           head entry
//   full, empty     occupancy flags
//   level           number of stored entries
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign rdata = mem[rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/cw305_cmd_regs.sv
// cw305_cmd_regs: byte-wide CW305 USB register block feeding the OBI bridge.
// Build option: CW305_CMD_REGS_FIFO_EN selects a FIFO_DEPTH-entry instruction
// queue (cmd_fifo); without it a single holding register is used.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   reg_address/bytecnt/datai  register select, byte lane, write byte
//   reg_write, reg_read        write strobe, read strobe
//   reg_datao                  registered read byte
//   instruction, instr_valid   queued instruction head and non-empty flag
//   rst_instr_valid            bridge pop pulse
//   new_section_address        committed section address
//   addr_valid                 address pending; rst_new_address_valid clears it
//   busy                       bridge busy, visible in STATUS
//   OBI_rvalid, OBI_rdata      OBI read response capture
//
// Handshake: instruction is valid whenever instr_valid=1; the bridge consumes
// it by pulsing rst_instr_valid for one cycle, and the next entry (if any)
// appears on instruction the following cycle. A pulse while empty is ignored.
module cw305_cmd_regs import cw305_cmd_pkg::*; #(
   parameter int ADDR_W     = 8,
   parameter int BYTECNT_W  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    reg_address,
   input  logic [BYTECNT_W-1:0] reg_bytecnt,
   input  logic [7:0]           reg_datai,
   input  logic                 reg_write,
   input  logic                 reg_read,
   output logic [7:0]           reg_datao,
   output logic [31:0]          instruction,
   output logic                 instr_valid,
   input  logic                 rst_instr_valid,
   output logic [31:0]          new_section_address,
   output logic                 addr_valid,
   input  logic                 rst_new_address_valid,
   input  logic                 busy,
   input  logic                 OBI_rvalid,
   input  logic [31:0]          OBI_rdata
);

   logic [1:0]  bidx;
   logic        wr_instr, wr_addr, wr_status0;
   logic        instr_push, addr_commit;
   logic [31:0] instr_stage, addr_stage, rdata_q, instr_word;
   logic        fifo_full, overflow, rdata_valid;
   logic [7:0]  level_byte, rd_mux;
   status_t     status;

   assign bidx       = reg_bytecnt[1:0];
   assign wr_instr   = reg_write && (reg_address == ADDR_W'(REG_INSTR));
   assign wr_addr    = reg_write && (reg_address == ADDR_W'(REG_ADDR));
   assign wr_status0 = reg_write && (reg_address == ADDR_W'(REG_STATUS)) && (bidx == 2'd0);

   // The byte-3 write commits using the incoming byte, not the staged copy.
   assign instr_push  = wr_instr && (bidx == 2'd3);
   assign addr_commit = wr_addr && (bidx == 2'd3);
   assign instr_word  = {reg_datai, instr_stage[23:0]};

`ifdef CW305_CMD_REGS_FIFO_EN
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   logic [LVL_W-1:0] fifo_level;
   logic             fifo_empty;

   cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (instr_push),
      .wdata (instr_word),
      .pop   (rst_instr_valid),
      .rdata (instruction),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign instr_valid = !fifo_empty;
   assign level_byte  = 8'(fifo_level);
`else
   // FIFO_DEPTH has no effect with the single holding register.
   localparam int unused_fifo_depth = FIFO_DEPTH;
   logic [31:0] hold_q;
   logic        hold_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
         hold_v <= 1'b0;
      end else if (instr_push && (!hold_v || rst_instr_valid)) begin
         hold_q <= instr_word;
         hold_v <= 1'b1;
      end else if (rst_instr_valid) begin
         hold_v <= 1'b0;
      end
   end

   assign instruction = hold_q;
   assign instr_valid = hold_v;
   assign fifo_full   = hold_v;
   assign level_byte  = {7'd0, hold_v};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_stage         <= '0;
         addr_stage          <= '0;
         new_section_address <= '0;
         addr_valid          <= 1'b0;
         rdata_q             <= '0;
         rdata_valid         <= 1'b0;
         overflow            <= 1'b0;
         reg_datao           <= '0;
      end else begin
         if (wr_instr) instr_stage[{bidx, 3'b000} +: 8] <= reg_datai;
         if (wr_addr)  addr_stage[{bidx, 3'b000} +: 8]  <= reg_datai;

         // A new commit beats a same-cycle clear from the bridge.
         if (addr_commit) begin
            new_section_address <= {reg_datai, addr_stage[23:0]};
            addr_valid          <= 1'b1;
         end else if (rst_new_address_valid) begin
            addr_valid <= 1'b0;
         end

         if (OBI_rvalid) begin
            rdata_q     <= OBI_rdata;
            rdata_valid <= 1'b1;
         end else if (wr_status0 && reg_datai[ST_RDATA_VALID]) begin
            rdata_valid <= 1'b0;
         end

         if (instr_push && fifo_full && !rst_instr_valid) begin
            overflow <= 1'b1;
         end else if (wr_status0 && reg_datai[ST_OVERFLOW]) begin
            overflow <= 1'b0;
         end

         if (reg_read) reg_datao <= rd_mux;
      end
   end

   always_comb begin
      status             = '0;
      status.instr_valid = instr_valid;
      status.addr_valid  = addr_valid;
      status.busy        = busy;
      status.rdata_valid = rdata_valid;
      status.fifo_full   = fifo_full;
      status.overflow    = overflow;
   end

   always_comb begin
      rd_mux = 8'h00;
      if (reg_address == ADDR_W'(REG_STATUS) && bidx == 2'd0) begin
         rd_mux = status;
      end else if (reg_address == ADDR_W'(REG_RDATA)) begin
         rd_mux = rdata_q[{bidx, 3'b000} +: 8];
      end else if (reg_address == ADDR_W'(REG_LEVEL) && bidx == 2'd0) begin
         rd_mux = level_byte;
      end
   end

endmodule

// File: tb/tb_cw305_cmd_regs.sv
`timescale 1ns/1ps
module tb_cw305_cmd_regs;
   import cw305_cmd_pkg::*;

`ifdef CW305_CMD_REGS_FIFO_EN
   localparam int M_DEPTH = 4;
`else
   localparam int M_DEPTH = 1;
`endif

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  reg_address = '0;
   logic [1:0]  reg_bytecnt = '0;
   logic [7:0]  reg_datai = '0;
   logic        reg_write = 1'b0;
   logic        reg_read = 1'b0;
   logic [7:0]  reg_datao;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        rst_instr_valid = 1'b0;
   logic [31:0] new_section_address;
   logic        addr_valid;
   logic        rst_new_address_valid = 1'b0;
   logic        busy = 1'b0;
   logic        OBI_rvalid = 1'b0;
   logic [31:0] OBI_rdata = '0;

   cw305_cmd_regs #(.ADDR_W(8), .BYTECNT_W(2), .FIFO_DEPTH(4)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .reg_address           (reg_address),
      .reg_bytecnt           (reg_bytecnt),
      .reg_datai             (reg_datai),
      .reg_write             (reg_write),
      .reg_read              (reg_read),
      .reg_datao             (reg_datao),
      .instruction           (instruction),
      .instr_valid           (instr_valid),
      .rst_instr_valid       (rst_instr_valid),
      .new_section_address   (new_section_address),
      .addr_valid            (addr_valid),
      .rst_new_address_valid (rst_new_address_valid),
      .busy                  (busy),
      .OBI_rvalid            (OBI_rvalid),
      .OBI_rdata             (OBI_rdata)
   );

   // ---------------- reference model ----------------
   logic [31:0] exp_q[$];
   logic [31:0] m_istage, m_astage, m_addr, m_rdata;
   bit          m_av, m_rv, m_ovf;
   logic [7:0]  m_datao;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_istage = '0; m_astage = '0; m_addr = '0; m_rdata = '0;
      m_av = 0; m_rv = 0; m_ovf = 0; m_datao = '0;
   endtask

   function automatic logic [7:0] exp_read(input logic [7:0] a, input logic [1:0] bc, input bit bsy);
      logic [31:0] r;
      r = m_rdata;
      if (a == REG_STATUS && bc == 2'd0)
         return {2'b00, m_ovf, exp_q.size() == M_DEPTH, m_rv, bsy, m_av, exp_q.size() > 0};
      if (a == REG_RDATA) return r[8*int'(bc) +: 8];
      if (a == REG_LEVEL && bc == 2'd0) return 8'(exp_q.size());
      return 8'h00;
   endfunction

   task automatic check_outputs();
      check("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("instruction", instruction, exp_q[0]);
      check("addr_valid", 32'(addr_valid), 32'(m_av));
      check("section_addr", new_section_address, m_addr);
      check("reg_datao", 32'(reg_datao), 32'(m_datao));
   endtask

   // ---------------- driver ----------------
   // Applies one cycle of inputs, advances the model by the same rules, then checks.
   task automatic drive(input bit wr, input logic [7:0] a, input logic [1:0] bc, input logic [7:0] d,
                        input bit rd, input bit pop, input bit clr, input bit rv,
                        input logic [31:0] rdat, input bit bsy);
      bit push, popped, is_status0;
      reg_write = wr; reg_address = a; reg_bytecnt = bc; reg_datai = d; reg_read = rd;
      rst_instr_valid = pop; rst_new_address_valid = clr; OBI_rvalid = rv; OBI_rdata = rdat; busy = bsy;

      if (rd) m_datao = exp_read(a, bc, bsy);
      push = 0;
      if (wr && a == REG_INSTR) begin
         m_istage[8*int'(bc) +: 8] = d;
         push = (bc == 2'd3);
      end
      popped = pop && exp_q.size() > 0;
      if (push && !(exp_q.size() < M_DEPTH || popped)) begin
         m_ovf = 1;
         push = 0;
      end
      if (popped) void'(exp_q.pop_front());
      if (push) exp_q.push_back(m_istage);

      if (wr && a == REG_ADDR) m_astage[8*int'(bc) +: 8] = d;
      if (wr && a == REG_ADDR && bc == 2'd3) begin
         m_addr = m_astage; m_av = 1;
      end else if (clr) m_av = 0;

      is_status0 = wr && a == REG_STATUS && bc == 2'd0;
      if (rv) begin
         m_rdata = rdat; m_rv = 1;
      end else if (is_status0 && d[3]) m_rv = 0;
      if (is_status0 && d[5]) m_ovf = 0;

      @(posedge clk); #1;
      reg_write = 0; reg_read = 0; rst_instr_valid = 0; rst_new_address_valid = 0; OBI_rvalid = 0;
      check_outputs();
   endtask

   task automatic wr_byte(input logic [7:0] a, input logic [1:0] bc, input logic [7:0] d);
      drive(1, a, bc, d, 0, 0, 0, 0, '0, 0);
   endtask

   task automatic wr_word(input logic [7:0] a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) wr_byte(a, 2'(b), w[8*b +: 8]);
   endtask

   task automatic rd_byte(input logic [7:0] a, input logic [1:0] bc);
      drive(0, a, bc, 8'h00, 1, 0, 0, 0, '0, 0);
   endtask

   task automatic pop_one();
      drive(0, 8'h07, 2'd0, 8'h00, 0, 1, 0, 0, '0, 0);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] words[5];
   logic [31:0] w;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_addr_valid", 32'(addr_valid), 32'd0);
      check("rst_section_addr", new_section_address, 32'd0);
      check("rst_datao", 32'(reg_datao), 32'd0);
      rst = 0;
      @(posedge clk); #1;
      rd_byte(REG_STATUS, 2'd0);
      check("status_after_reset", 32'(reg_datao), 32'h00);

      // Instruction assembly and commit
      wr_word(REG_INSTR, 32'h00100513);
      check("instr_commit_valid", 32'(instr_valid), 32'd1);
      check("instr_commit_word", instruction, 32'h00100513);
      rd_byte(REG_LEVEL, 2'd0);
      check("level_one", 32'(reg_datao), 32'd1);
      pop_one();

      // Address commit, then commit racing a clear
      wr_word(REG_ADDR, 32'h00000100);
      check("addr_first", new_section_address, 32'h00000100);
      wr_byte(REG_ADDR, 2'd0, 8'h00);
      wr_byte(REG_ADDR, 2'd1, 8'h02);
      wr_byte(REG_ADDR, 2'd2, 8'h00);
      drive(1, REG_ADDR, 2'd3, 8'h00, 0, 0, 1, 0, '0, 0);
      check("addr_set_wins", 32'(addr_valid), 32'd1);
      check("addr_second", new_section_address, 32'h00000200);
      drive(0, 8'h07, 2'd0, 8'h00, 0, 0, 1, 0, '0, 0);

      // Overflow: five pushes, no pops
      for (int i = 0; i < 5; i++) begin
         words[i] = $urandom;
         wr_word(REG_INSTR, words[i]);
      end
      rd_byte(REG_STATUS, 2'd0);
      check("status_full_ovf", 32'(reg_datao), 32'h31);
      rd_byte(REG_LEVEL, 2'd0);
      check("level_full", 32'(reg_datao), 32'(M_DEPTH));
      for (int i = 0; i < M_DEPTH; i++) begin
         check("fifo_order", instruction, words[i]);
         pop_one();
      end
      check("drained", 32'(instr_valid), 32'd0);
      pop_one();
      wr_byte(REG_STATUS, 2'd0, 8'h20);
      rd_byte(REG_STATUS, 2'd0);
      check("ovf_cleared", 32'(reg_datao), 32'h00);

      // Simultaneous push and pop with two entries held
      for (int i = 0; i < 2; i++) begin
         words[i] = $urandom;
         wr_word(REG_INSTR, words[i]);
      end
      rd_byte(REG_LEVEL, 2'd0);
      w = $urandom;
      for (int b = 0; b < 3; b++) wr_byte(REG_INSTR, 2'(b), w[8*b +: 8]);
      drive(1, REG_INSTR, 2'd3, w[31:24], 0, 1, 0, 0, '0, 0);
      rd_byte(REG_LEVEL, 2'd0);
      while (exp_q.size() > 0) pop_one();
      wr_byte(REG_STATUS, 2'd0, 8'h20);

      // OBI read data capture and software clear
      drive(0, 8'h07, 2'd0, 8'h00, 0, 0, 0, 1, 32'hDEADBEEF, 0);
      rd_byte(REG_RDATA, 2'd0); check("rdata_b0", 32'(reg_datao), 32'hEF);
      rd_byte(REG_RDATA, 2'd1); check("rdata_b1", 32'(reg_datao), 32'hBE);
      rd_byte(REG_RDATA, 2'd2); check("rdata_b2", 32'(reg_datao), 32'hAD);
      rd_byte(REG_RDATA, 2'd3); check("rdata_b3", 32'(reg_datao), 32'hDE);
      rd_byte(REG_STATUS, 2'd0);
      check("rdata_valid_set", 32'(reg_datao[3]), 32'd1);
      wr_byte(REG_STATUS, 2'd0, 8'h08);
      rd_byte(REG_STATUS, 2'd0);
      check("rdata_valid_clr", 32'(reg_datao[3]), 32'd0);
      // capture beats a same-cycle clear
      drive(1, REG_STATUS, 2'd0, 8'h08, 0, 0, 0, 1, 32'h12345678, 0);
      rd_byte(REG_STATUS, 2'd0);
      check("rvalid_priority", 32'(reg_datao[3]), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 2) == 0) ? 8'(REG_INSTR) : 8'($urandom_range(0, 5));
         drive($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), 8'($urandom),
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom,
               $urandom_range(0, 1) == 1);
      end

      // Reset in the middle of activity
      wr_word(REG_INSTR, $urandom);
      pop_one();
      wr_word(REG_INSTR, $urandom);
      wr_byte(REG_INSTR, 2'd0, 8'hAA);
      wr_byte(REG_INSTR, 2'd1, 8'hBB);
      rd_byte(REG_LEVEL, 2'd0);
      rst = 1;
      #2;
      model_reset();
      check("midrst_instr_valid", 32'(instr_valid), 32'd0);
      check("midrst_datao", 32'(reg_datao), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      rd_byte(REG_LEVEL, 2'd0);
      check("midrst_level", 32'(reg_datao), 32'd0);
      wr_byte(REG_INSTR, 2'd3, 8'h5A);
      check("stage_cleared", instruction, 32'h5A000000);
      pop_one();
      wr_word(REG_INSTR, 32'hCAFE0013);
      check("post_rst_commit", instruction, 32'hCAFE0013);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
